load_store_unit: RTL and testbench

- Initiator side of the data-memory interface. Accepts load/store requests from the CPU datapath and drives MemRead/MemWrite/Address/din into the byte-addressed, big-endian, word-ported data memory.
- Returns load data.
- Handles byte and halfword loads with sign/zero extension.
- Handles sub-word stores by read-modify-write.
- Rejects misaligned or out-of-range accesses without touching memory.

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a big-endian, word-ported data memory.
// Sub-word loads are extended, and sub-word stores are done by read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] din,
    input  logic [31:0] dout
);

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [32:0] last_byte;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Extra bit keeps the range check honest for addresses near the top of the space.
    assign last_byte = {1'b0, req_addr[31:2], 2'b00} + 33'd3;

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SzByte:  req_err = 1'b0;
            SzHalf:  req_err = req_addr[0];
            SzWord:  req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (last_byte >= 33'(MEM_BYTES)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        byte_lane = dout[31:24];
        unique case (addr_q[1:0])
            2'd0: byte_lane = dout[31:24];
            2'd1: byte_lane = dout[23:16];
            2'd2: byte_lane = dout[15:8];
            2'd3: byte_lane = dout[7:0];
        endcase
        half_lane = addr_q[1] ? dout[15:0] : dout[31:16];

        load_val = dout;
        if (size_q == SzByte) begin
            load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
        end else if (size_q == SzHalf) begin
            load_val = {{16{signed_q & half_lane[15]}}, half_lane};
        end
    end

    always_comb begin
        merged = dout;
        if (size_q == SzByte) begin
            unique case (addr_q[1:0])
                2'd0: merged[31:24] = data_q[7:0];
                2'd1: merged[23:16] = data_q[7:0];
                2'd2: merged[15:8]  = data_q[7:0];
                2'd3: merged[7:0]   = data_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = data_q[15:0];
        end else begin
            merged[31:16] = data_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    data_d   = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && req_size == SzWord) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (we_q) begin
                    data_d  = merged;
                    state_d = StWrite;
                end else begin
                    rdata_d = load_val;
                    state_d = StResp;
                end
            end
            StWrite: state_d = StResp;
            StResp: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Decoded straight from state so an asynchronous reset drops MemWrite at once.
    always_comb begin
        req_ready  = (state_q == StIdle);
        MemRead    = (state_q == StRead);
        MemWrite   = (state_q == StWrite);
        Address    = (MemRead || MemWrite) ? {addr_q[31:2], 2'b00} : 32'h0;
        din        = MemWrite ? data_q : 32'h0;
        resp_valid = (state_q == StResp);
        resp_rdata = resp_valid ? rdata_q : 32'h0;
        resp_err   = resp_valid & err_q;
    end

    assert property (@(posedge CLK) disable iff (!RST) !(MemRead && MemWrite));
    assert property (@(posedge CLK) disable iff (!RST) (MemRead || MemWrite) |-> !err_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small big-endian word memory model.
module tb_load_store_unit;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] din;
    logic [31:0] dout;

    logic [31:0] mem [0:31];

    int n_pass;
    int n_total;

    int          lat, n_rd, n_wr;
    logic [31:0] rdata, wa, wd;
    logic        err;

    load_store_unit #(.MEM_BYTES(128)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .din        (din),
        .dout       (dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign dout = MemRead ? mem[Address[6:2]] : 32'h0;
    always @(negedge CLK) if (MemWrite) mem[Address[6:2]] <= din;

    // Drives one request and measures it; comparisons live in the test tasks.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        lat = 0; n_rd = 0; n_wr = 0; rdata = 32'h0; wa = 32'h0; wd = 32'h0; err = 1'b0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_size = 2'b11;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (MemRead) n_rd++;
            if (MemWrite) begin
                n_wr++; wa = Address; wd = din;
            end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
        n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else n_pass++;
        n_total++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", resp_rdata); else n_pass++;
        n_total++; if (resp_err !== 1'b0) $display("FAIL reset_err got %b want 0", resp_err); else n_pass++;
        n_total++; if ({MemRead, MemWrite} !== 2'b00) $display("FAIL reset_mem_en got %b want 00", {MemRead, MemWrite}); else n_pass++;
        n_total++; if (Address !== 32'h0) $display("FAIL reset_addr got %h want 0", Address); else n_pass++;
        n_total++; if (din !== 32'h0) $display("FAIL reset_din got %h want 0", din); else n_pass++;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_word_store_load();
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        n_total++; if (lat !== 2) $display("FAIL sw_lat got %0d want 2", lat); else n_pass++;
        n_total++; if (n_wr !== 1) $display("FAIL sw_wr_cycles got %0d want 1", n_wr); else n_pass++;
        n_total++; if (n_rd !== 0) $display("FAIL sw_rd_cycles got %0d want 0", n_rd); else n_pass++;
        n_total++; if (wa !== 32'h10) $display("FAIL sw_addr got %h want 00000010", wa); else n_pass++;
        n_total++; if (wd !== 32'hDEAD_BEEF) $display("FAIL sw_din got %h want deadbeef", wd); else n_pass++;
        n_total++; if (err !== 1'b0 || rdata !== 32'h0) $display("FAIL sw_resp got err=%b rdata=%h want 0/0", err, rdata); else n_pass++;
        n_total++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL sw_mem got %h want deadbeef", mem[4]); else n_pass++;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_total++; if (lat !== 2) $display("FAIL lw_lat got %0d want 2", lat); else n_pass++;
        n_total++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got %h want deadbeef", rdata); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL lw_err got %b want 0", err); else n_pass++;
        n_total++; if (n_rd !== 1 || n_wr !== 0) $display("FAIL lw_mem_cycles got rd=%0d wr=%0d want 1/0", n_rd, n_wr); else n_pass++;
    endtask

    task automatic test_byte_loads();
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a, e;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01);
        n_total++; if (mem[8] !== 32'h80FF_7F01) $display("FAIL preload20 got %h want 80ff7f01", mem[8]); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin sz = 2'b00; sg = 1'b1; a = 32'h20; e = 32'hFFFF_FF80; end
                1: begin sz = 2'b00; sg = 1'b0; a = 32'h21; e = 32'h0000_00FF; end
                2: begin sz = 2'b00; sg = 1'b1; a = 32'h22; e = 32'h0000_007F; end
                3: begin sz = 2'b01; sg = 1'b0; a = 32'h22; e = 32'h0000_7F01; end
                default: begin sz = 2'b01; sg = 1'b1; a = 32'h20; e = 32'hFFFF_80FF; end
            endcase
            issue(1'b0, sz, sg, a, 32'h0);
            n_total++;
            if (rdata !== e || err !== 1'b0 || lat !== 2)
                $display("FAIL subload%0d got rdata=%h err=%b lat=%0d want %h/0/2", i, rdata, err, lat, e);
            else n_pass++;
        end
    endtask

    task automatic test_rmw();
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFF_FFAB);
        n_total++; if (lat !== 3) $display("FAIL sb_lat got %0d want 3", lat); else n_pass++;
        n_total++; if (n_rd !== 1 || n_wr !== 1) $display("FAIL sb_cycles got rd=%0d wr=%0d want 1/1", n_rd, n_wr); else n_pass++;
        n_total++; if (wa !== 32'h30) $display("FAIL sb_addr got %h want 00000030", wa); else n_pass++;
        n_total++; if (wd !== 32'h11AB_3344) $display("FAIL sb_din got %h want 11ab3344", wd); else n_pass++;
        issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234_CAFE);
        n_total++; if (lat !== 3) $display("FAIL sh_lat got %0d want 3", lat); else n_pass++;
        n_total++; if (wd !== 32'h11AB_CAFE) $display("FAIL sh_din got %h want 11abcafe", wd); else n_pass++;
        n_total++; if (mem[12] !== 32'h11AB_CAFE) $display("FAIL sh_mem got %h want 11abcafe", mem[12]); else n_pass++;
    endtask

    task automatic test_errors();
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin we = 1'b0; sz = 2'b10; a = 32'h02; end
                1: begin we = 1'b0; sz = 2'b01; a = 32'h05; end
                2: begin we = 1'b0; sz = 2'b11; a = 32'h00; end
                default: begin we = 1'b1; sz = 2'b10; a = 32'h80; end
            endcase
            issue(we, sz, 1'b0, a, 32'h5A5A_5A5A);
            n_total++;
            if (lat !== 1 || err !== 1'b1 || rdata !== 32'h0 || n_rd !== 0 || n_wr !== 0)
                $display("FAIL err%0d got lat=%0d err=%b rdata=%h rd=%0d wr=%0d want 1/1/0/0/0",
                         i, lat, err, rdata, n_rd, n_wr);
            else n_pass++;
        end
        @(negedge CLK);
        n_total++; if (resp_err !== 1'b0 || resp_valid !== 1'b0) $display("FAIL err_clear got err=%b valid=%b want 0/0", resp_err, resp_valid); else n_pass++;
        issue(1'b1, 2'b10, 1'b0, 32'h7C, 32'hA5A5_0F0F);
        n_total++; if (lat !== 2 || err !== 1'b0 || n_wr !== 1) $display("FAIL sw7c got lat=%0d err=%b wr=%0d want 2/0/1", lat, err, n_wr); else n_pass++;
        n_total++; if (mem[31] !== 32'hA5A5_0F0F) $display("FAIL sw7c_mem got %h want a5a50f0f", mem[31]); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int seen;
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h0102_0304);
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h5555_5555;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        n_total++; if (MemWrite !== 1'b1 || din !== 32'h5555_5555) $display("FAIL rst_pre_write got we=%b din=%h want 1/55555555", MemWrite, din); else n_pass++;
        #2;
        RST = 1'b0;
        #1;
        n_total++; if (MemWrite !== 1'b0) $display("FAIL rst_memwrite got %b want 0", MemWrite); else n_pass++;
        n_total++; if (req_ready !== 1'b1 || Address !== 32'h0) $display("FAIL rst_idle got ready=%b addr=%h want 1/0", req_ready, Address); else n_pass++;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (resp_valid) seen++;
        end
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (resp_valid) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rst_no_resp got %0d responses want 0", seen); else n_pass++;
        n_total++; if (mem[16] !== 32'h0102_0304) $display("FAIL rst_mem got %h want 01020304", mem[16]); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp [3];
        logic [31:0] got [3];
        int acc_cyc [3];
        int idx, nresp;
        logic acc;
        addrs[0] = 32'h10; exp[0] = 32'hDEAD_BEEF;
        addrs[1] = 32'h20; exp[1] = 32'h80FF_7F01;
        addrs[2] = 32'h30; exp[2] = 32'h11AB_CAFE;
        for (int i = 0; i < 3; i++) begin got[i] = 32'h0; acc_cyc[i] = -1; end
        idx = 0; nresp = 0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = addrs[0];
        for (int c = 0; c < 12; c++) begin
            if (resp_valid) begin
                if (nresp < 3) got[nresp] = resp_rdata;
                nresp++;
            end
            acc = req_valid && req_ready;
            @(posedge CLK);
            #1;
            if (acc) begin
                if (idx < 3) acc_cyc[idx] = c;
                idx++;
                if (idx < 3) req_addr = addrs[idx]; else req_valid = 1'b0;
            end
            @(negedge CLK);
        end
        req_valid = 1'b0;
        n_total++; if (idx !== 3) $display("FAIL b2b_accepts got %0d want 3", idx); else n_pass++;
        n_total++; if (nresp !== 3) $display("FAIL b2b_responses got %0d want 3", nresp); else n_pass++;
        n_total++; if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3)
            $display("FAIL b2b_spacing got %0d,%0d,%0d want gaps of 3", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL b2b_rdata%0d got %h want %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_word_store_load();
        test_byte_loads();
        test_rmw();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
